// File: rtl/maj_seq_eval_if.sv
// rtl/maj_seq_eval_if.sv - program, input-stream and result-stream bundle for maj_seq_eval
//
// Purpose: groups the host program bus, the input vector stream and the
// result stream of the MAJ3 evaluator.
// Ports (signals):
//   prog_we, prog_addr[4:0], prog_data[17:0], prog_len[4:0]  host -> evaluator
//   in_valid, in_x[6:0] -> / <- in_ready                       input vector stream
//   out_valid, out_y, out_err -> / <- out_ready                result stream
//   busy                                                       evaluator status
// Modports: master (host/bench side), slave (evaluator side).
interface maj_seq_eval_if;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [17:0] prog_data;
    logic [4:0]  prog_len;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_x;
    logic        out_valid;
    logic        out_ready;
    logic        out_y;
    logic        out_err;
    logic        busy;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_y, out_err, busy
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, in_valid, in_x, out_ready,
        output in_ready, out_valid, out_y, out_err, busy
    );
endinterface

// File: rtl/maj_seq_eval.sv
// rtl/maj_seq_eval.sv - time-multiplexed majority-of-three network evaluator
//
// Purpose: evaluates a programmed MAJ3 network over 7 primary inputs, one node
// per cycle through a single shared MAJ3 unit, in program order.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   bus (slave)    program bus, input vector stream, result stream, busy
//   trace_valid/trace_idx/trace_val  per-node trace, present only when the
//                  macro MAJ_SEQ_EVAL_TRACE_EN is defined
// Node word: op0 = [5:0], op1 = [11:6], op2 = [17:12]; operand bit5 = invert,
// bits4:0 = select (0 const0, 1..7 x0..x6, 8.. node registers).
module maj_seq_eval #(
    parameter int MAX_NODES = 16,
    parameter int NUM_IN    = 7
) (
    input  logic           clk,
    input  logic           rst,
    maj_seq_eval_if.slave  bus
`ifdef MAJ_SEQ_EVAL_TRACE_EN
    ,
    output logic           trace_valid,
    output logic [4:0]     trace_idx,
    output logic           trace_val
`endif
);

    localparam int         IW      = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam int         PDEPTH  = 1 << IW;
    localparam logic [5:0] MAXN6   = 6'(MAX_NODES);
    localparam logic [5:0] SEL_END = 6'(8 + MAX_NODES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [NUM_IN-1:0]   x_q;
    logic [4:0]          len_q;
    logic [4:0]          idx_q;
    logic [31:0]         node_q;
    logic                err_q;
    logic                out_valid_q;
    logic                out_y_q;
    logic                out_err_q;
    logic                busy_q;

    // Program memory is deliberately left out of reset.
    logic [17:0]         prog_mem [PDEPTH];

    logic [NUM_IN:0]     x_ext;
    logic [17:0]         node_word;
    logic [1:0]          d0, d1, d2;
    logic                maj;
    logic                node_err;
    logic                addr_ok;
    logic                len_bad;
    logic                last_node;

    // Returns {error, operand bit}. Errored operands read 0 before inversion.
    function automatic logic [1:0] dec_op(
        input logic [5:0]      op,
        input logic [NUM_IN:0] xe,
        input logic [31:0]     nodes,
        input logic [4:0]      idx
    );
        logic [4:0] sel;
        logic [4:0] k;
        logic       b;
        logic       e;
        sel = op[4:0];
        k   = sel - 5'd8;
        b   = 1'b0;
        e   = 1'b0;
        if (sel < 5'd8) begin
            // xe[0] is the constant-0 slot, xe[i] = x(i-1)
            b = xe[sel[2:0]];
        end else if ({1'b0, sel} < SEL_END) begin
            // Only already-evaluated nodes are legal sources
            if (k >= idx) begin
                e = 1'b1;
            end else begin
                b = nodes[k];
            end
        end else begin
            e = 1'b1;
        end
        return {e, b ^ op[5]};
    endfunction

    assign x_ext     = {x_q, 1'b0};
    assign node_word = prog_mem[idx_q[IW-1:0]];
    assign d0        = dec_op(node_word[5:0],   x_ext, node_q, idx_q);
    assign d1        = dec_op(node_word[11:6],  x_ext, node_q, idx_q);
    assign d2        = dec_op(node_word[17:12], x_ext, node_q, idx_q);
    assign maj       = (d0[0] & d1[0]) | (d0[0] & d2[0]) | (d1[0] & d2[0]);
    assign node_err  = d0[1] | d1[1] | d2[1];

    assign addr_ok   = ({1'b0, bus.prog_addr} < MAXN6);
    assign len_bad   = (bus.prog_len == 5'd0) || ({1'b0, bus.prog_len} > MAXN6);
    assign last_node = (idx_q == (len_q - 5'd1));

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.prog_we && addr_ok) begin
            prog_mem[bus.prog_addr[IW-1:0]] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            node_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            out_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x_q    <= bus.in_x;
                        len_q  <= bus.prog_len;
                        idx_q  <= '0;
                        node_q <= '0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len_bad) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_y_q     <= 1'b0;
                            out_err_q   <= 1'b1;
                        end else begin
                            state_q <= S_EVAL;
                        end
                    end
                end
                S_EVAL: begin
                    node_q[idx_q] <= maj;
                    err_q         <= err_q | node_err;
                    if (last_node) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_y_q     <= maj;
                        out_err_q   <= err_q | node_err;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = busy_q;

`ifdef MAJ_SEQ_EVAL_TRACE_EN
    assign trace_valid = (state_q == S_EVAL);
    assign trace_idx   = (state_q == S_EVAL) ? idx_q : 5'd0;
    assign trace_val   = (state_q == S_EVAL) & maj;
`endif

endmodule
